// File: rtl/invaes_pkg.sv
// Shared types and key-size helpers for the inverse-AES round sequencer.
package invaes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KEYEXP,
    ROUND0,
    ROUNDS,
    FINAL,
    DONE
  } rc_state_t;

  function automatic int nk(input int k);
    return k / 32;
  endfunction

  function automatic int nr(input int k);
    return nk(k) + 6;
  endfunction

  function automatic int nw(input int k);
    return 4 * (nr(k) + 1);
  endfunction

endpackage

// File: rtl/invaes_round_ctrl_if.sv
// Control bundle from the round sequencer to the key-expansion unit and round datapath.
interface invaes_round_ctrl_if;
  logic       kx_init;
  logic       kx_en;
  logic [5:0] kx_idx;
  logic       rnd_en;
  logic [3:0] rnd_idx;
  logic       rnd_first;
  logic       rnd_last;
  logic       done;

  modport master (
    output kx_init, kx_en, kx_idx, rnd_en, rnd_idx, rnd_first, rnd_last, done
  );

  modport slave (
    input kx_init, kx_en, kx_idx, rnd_en, rnd_idx, rnd_first, rnd_last, done
  );
endinterface

// File: rtl/invaes_sync_edge.sv
// Two-flop synchroniser for the asynchronous load pin, with registered rise/fall pulses.
module invaes_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta, sync, sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/invaes_round_ctrl.sv
// Inverse-AES sequencer: one key-expansion pass then NR+1 rounds per load falling edge.
// Optional INVAES_KEYCACHE_EN skips key expansion when the key is unchanged.
module invaes_round_ctrl
  import invaes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
`ifdef INVAES_KEYCACHE_EN
  input  logic key_same,
`endif
  invaes_round_ctrl_if.master bus
);

  localparam int NK = nk(K);
  localparam int NR = nr(K);
  localparam int NW = nw(K);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("invaes_round_ctrl: K must be 128, 192 or 256");
  end

  logic       start, abort, cache_hit;
  rc_state_t  state;
  logic       kx_init_q, kx_en_q, rnd_en_q, rnd_first_q, rnd_last_q, done_q;
  logic [5:0] kx_idx_q;
  logic [3:0] rnd_idx_q;

  invaes_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (load),
    .rise  (abort),
    .fall  (start)
  );

`ifdef INVAES_KEYCACHE_EN
  logic cache_vld;

  // A normal return from DONE keeps the cached schedule; any other abort discards it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_vld <= 1'b0;
    end else if (abort && state != IDLE && state != DONE) begin
      cache_vld <= 1'b0;
    end else if (state == KEYEXP && kx_idx_q == 6'(NW - 1)) begin
      cache_vld <= 1'b1;
    end
  end

  assign cache_hit = key_same & cache_vld;
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      kx_init_q   <= 1'b0;
      kx_en_q     <= 1'b0;
      kx_idx_q    <= '0;
      rnd_en_q    <= 1'b0;
      rnd_idx_q   <= '0;
      rnd_first_q <= 1'b0;
      rnd_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      kx_init_q   <= 1'b0;
      kx_en_q     <= 1'b0;
      kx_idx_q    <= '0;
      rnd_en_q    <= 1'b0;
      rnd_idx_q   <= '0;
      rnd_first_q <= 1'b0;
      rnd_last_q  <= 1'b0;
      done_q      <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && cache_hit) begin
              state       <= ROUND0;
              rnd_en_q    <= 1'b1;
              rnd_first_q <= 1'b1;
              rnd_idx_q   <= 4'(NR);
            end else if (start) begin
              state     <= INIT;
              kx_init_q <= 1'b1;
            end
          end
          INIT: begin
            state    <= KEYEXP;
            kx_en_q  <= 1'b1;
            kx_idx_q <= 6'(NK);
          end
          KEYEXP: begin
            if (kx_idx_q == 6'(NW - 1)) begin
              state       <= ROUND0;
              rnd_en_q    <= 1'b1;
              rnd_first_q <= 1'b1;
              rnd_idx_q   <= 4'(NR);
            end else begin
              kx_en_q  <= 1'b1;
              kx_idx_q <= kx_idx_q + 6'd1;
            end
          end
          ROUND0: begin
            state     <= ROUNDS;
            rnd_en_q  <= 1'b1;
            rnd_idx_q <= 4'(NR - 1);
          end
          ROUNDS: begin
            rnd_en_q <= 1'b1;
            if (rnd_idx_q == 4'd1) begin
              state      <= FINAL;
              rnd_last_q <= 1'b1;
              rnd_idx_q  <= 4'd0;
            end else begin
              rnd_idx_q <= rnd_idx_q - 4'd1;
            end
          end
          FINAL: begin
            state  <= DONE;
            done_q <= 1'b1;
          end
          DONE: begin
            done_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.kx_init   = kx_init_q;
  assign bus.kx_en     = kx_en_q;
  assign bus.kx_idx    = kx_idx_q;
  assign bus.rnd_en    = rnd_en_q;
  assign bus.rnd_idx   = rnd_idx_q;
  assign bus.rnd_first = rnd_first_q;
  assign bus.rnd_last  = rnd_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_invaes_round_ctrl.sv
// Scoreboard bench for invaes_round_ctrl at K=128/192/256; honours INVAES_KEYCACHE_EN.
module tb_invaes_round_ctrl;
  import invaes_pkg::*;

`ifdef INVAES_KEYCACHE_EN
  localparam bit CACHE = 1'b1;
  logic key_same;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        load_v [3];
  logic [15:0] obs [3];
  logic [15:0] exp_q [$];
  int          checks;
  int          errors;

  invaes_round_ctrl_if ifc0 ();
  invaes_round_ctrl_if ifc1 ();
  invaes_round_ctrl_if ifc2 ();

  invaes_round_ctrl #(.K(128)) u_dut0 (
    .clk(clk), .reset(reset), .load(load_v[0]),
`ifdef INVAES_KEYCACHE_EN
    .key_same(key_same),
`endif
    .bus(ifc0)
  );

  invaes_round_ctrl #(.K(192)) u_dut1 (
    .clk(clk), .reset(reset), .load(load_v[1]),
`ifdef INVAES_KEYCACHE_EN
    .key_same(key_same),
`endif
    .bus(ifc1)
  );

  invaes_round_ctrl #(.K(256)) u_dut2 (
    .clk(clk), .reset(reset), .load(load_v[2]),
`ifdef INVAES_KEYCACHE_EN
    .key_same(key_same),
`endif
    .bus(ifc2)
  );

  // Bit layout: kx_init, kx_en, kx_idx[5:0], rnd_en, rnd_idx[3:0], rnd_first, rnd_last, done
  assign obs[0] = {ifc0.kx_init, ifc0.kx_en, ifc0.kx_idx, ifc0.rnd_en, ifc0.rnd_idx,
                   ifc0.rnd_first, ifc0.rnd_last, ifc0.done};
  assign obs[1] = {ifc1.kx_init, ifc1.kx_en, ifc1.kx_idx, ifc1.rnd_en, ifc1.rnd_idx,
                   ifc1.rnd_first, ifc1.rnd_last, ifc1.done};
  assign obs[2] = {ifc2.kx_init, ifc2.kx_en, ifc2.kx_idx, ifc2.rnd_en, ifc2.rnd_idx,
                   ifc2.rnd_first, ifc2.rnd_last, ifc2.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] mk(input bit ki, input bit ke, input int kidx, input bit re,
                                     input int ridx, input bit f, input bit l, input bit d);
    logic [5:0] k6;
    logic [3:0] r4;
    k6 = 6'(kidx);
    r4 = 4'(ridx);
    return {ki, ke, k6, re, r4, f, l, d};
  endfunction

  // Expected per-cycle trace from the pin drop to the first done cycle; returns the latency.
  function automatic int push_run(input int k, input bit cached);
    int knk, knr, knw;
    knk = k / 32;
    knr = knk + 6;
    knw = 4 * (knr + 1);
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
    if (!cached) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int i = knk; i < knw; i++) exp_q.push_back(mk(0, 1, i, 0, 0, 0, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 1, knr, 1, 0, 0));
    for (int r = knr - 1; r >= 1; r--) exp_q.push_back(mk(0, 0, 0, 1, r, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    return cached ? knr + 1 : 2 + knw - knk + knr;
  endfunction

  task automatic step(input int d);
    logic [15:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    checkOutput("trace", 32'(obs[d]), 32'(e));
  endtask

  task automatic drain(input int d);
    while (exp_q.size() > 0) step(d);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'h0);
    drain(d);
  endtask

  // Drop load (start), follow the whole run, then raise load and see done clear.
  task automatic applyStimulus(input int d, input int k, input bit cached);
    int c, st, lat;
    bit seen;
    c = 0;
    st = -1;
    seen = 1'b0;
    lat = push_run(k, cached);
    load_v[d] = 1'b0;
    while (exp_q.size() > 0) begin
      step(d);
      c++;
      if (st < 0 && (obs[d][15] || obs[d][2])) st = c;
      if (!seen && obs[d][0]) begin
        seen = 1'b1;
        checkOutput("latency", 32'(c - st), 32'(lat));
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    load_v[d] = 1'b1;
    exp_q.push_back(16'h1);
    exp_q.push_back(16'h1);
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
    drain(d);
  endtask

  // Structural invariants checked on every cycle of every instance.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput("en_onehot", 32'($onehot0({obs[d][15], obs[d][14], obs[d][7]})), 32'd1);
        checkOutput("done_excl", 32'(obs[d][0] & (obs[d][15] | obs[d][14] | obs[d][7])), 32'd0);
        checkOutput("first_last", 32'(obs[d][2] & obs[d][1]), 32'd0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) load_v[i] = 1'b0;
`ifdef INVAES_KEYCACHE_EN
    key_same = 1'b0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("reset_out", 32'(obs[i]), 32'd0);
    reset = 1'b1;

    // K=128 basic run
    load_v[0] = 1'b1;
    idle(0, 4);
    applyStimulus(0, 128, 1'b0);

    // K=192 and K=256
    load_v[1] = 1'b1;
    idle(1, 4);
    applyStimulus(1, 192, 1'b0);
    load_v[2] = 1'b1;
    idle(2, 4);
    applyStimulus(2, 256, 1'b0);

    // Abort during key expansion at kx_idx=20, then a full restart
    idle(0, 2);
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 4; i <= 22; i++) exp_q.push_back(mk(0, 1, i, 0, 0, 0, 0, 0));
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
    load_v[0] = 1'b0;
    for (int i = 0; i < 20; i++) step(0);
    checkOutput("abort_pt", 32'(obs[0][13:8]), 32'd20);
    load_v[0] = 1'b1;
    drain(0);
    idle(0, 3);
    applyStimulus(0, 128, 1'b0);

    // Async reset during ROUNDS at rnd_idx=5
    idle(0, 2);
    exp_q.push_back(16'h0);
    exp_q.push_back(16'h0);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 4; i < 44; i++) exp_q.push_back(mk(0, 1, i, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 10, 1, 0, 0));
    for (int r = 9; r >= 5; r--) exp_q.push_back(mk(0, 0, 0, 1, r, 0, 0, 0));
    load_v[0] = 1'b0;
    drain(0);
    reset = 1'b0;
    #1;
    checkOutput("rst_async", 32'(obs[0]), 32'd0);
    checkOutput("rst_state", 32'(u_dut0.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    idle(0, 6);

    // Back-to-back runs with key_same=1, then key_same=0
    load_v[0] = 1'b1;
`ifdef INVAES_KEYCACHE_EN
    key_same = 1'b1;
`endif
    idle(0, 4);
    applyStimulus(0, 128, 1'b0);
    idle(0, 3);
    applyStimulus(0, 128, CACHE);
`ifdef INVAES_KEYCACHE_EN
    key_same = 1'b0;
`endif
    idle(0, 3);
    applyStimulus(0, 128, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
